// File: rtl/data_sram_responder.sv
// Multi-cycle data SRAM model answering the CPU M-stage data port.
// Each request stalls the CPU for LATENCY+1 cycles, then parks in DONE until the pipeline unfreezes.
module data_sram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    input  logic        longest_stall,
    output logic [31:0] data_sram_rdata,
    output logic        d_stall,
    output logic [1:0]  dbgState
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam int         DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    stateT                 state;
    logic [3:0]            count;
    logic [ADDR_WIDTH-1:0] reqIdx;
    logic [3:0]            reqWen;
    logic [31:0]           reqWdata;
    logic [31:0]           mem [DEPTH];
    logic                  accessNow;
    logic                  unusedAddrBits;

    assign accessNow = (state == BUSY) && (count == 4'd0);
    // Stall is raised in the very cycle a request appears so the CPU freezes before the next edge.
    assign d_stall   = !rst && (((state == IDLE) && data_sram_en) || (state == BUSY));
    assign dbgState  = state;

    // Byte offset and bits above the array are dropped, so addresses wrap around the depth.
    assign unusedAddrBits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            count           <= 4'd0;
            data_sram_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_sram_en) begin
                        reqIdx   <= data_sram_addr[ADDR_WIDTH+1:2];
                        reqWen   <= data_sram_wen;
                        reqWdata <= data_sram_wdata;
                        count    <= LOAD_COUNT;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        if (reqWen == 4'b0000) begin
                            data_sram_rdata <= mem[reqIdx];
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A frozen CPU still presents the same request; wait so it is not executed twice.
                    if (!longest_stall) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never cleared; a reset on the access edge drops the pending write.
    always_ff @(posedge clk) begin
        if (!rst && accessNow) begin
            for (int b = 0; b < 4; b++) begin
                if (reqWen[b]) begin
                    mem[reqIdx][8*b +: 8] <= reqWdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the ports are named clk and rst.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the word-index width (memory depth 2^ADDR_WIDTH words of 32 bits).
REQ-003 The block SHALL have parameter LATENCY, default 3, giving the number of wait cycles per access; legal values are 1..15.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port data_sram_en, input, 1 bit: CPU data request valid (M stage).
REQ-007 The block SHALL have port data_sram_wen, input, 4 bits: byte write enables; 0000 means a read.
REQ-008 The block SHALL have port data_sram_addr, input, 32 bits: byte address.
REQ-009 The block SHALL have port data_sram_wdata, input, 32 bits: write data, already lane-aligned by the CPU.
REQ-010 The block SHALL have port longest_stall, input, 1 bit: CPU global freeze indicator.
REQ-011 The block SHALL have port data_sram_rdata, output, 32 bits: registered read data.
REQ-012 The block SHALL have port d_stall, output, 1 bit: data-side stall request to the CPU.

Function
REQ-013 The block SHALL implement an FSM with the states IDLE, BUSY and DONE.
REQ-014 In IDLE with data_sram_en=1, the block SHALL latch addr, wen and wdata, load the counter with LATENCY-1 and enter BUSY.
REQ-015 d_stall SHALL be combinational: it is 1 when in IDLE with data_sram_en=1, or when in BUSY; it is 0 otherwise.
REQ-016 In BUSY with counter>0, the block SHALL decrement the counter.
REQ-017 In BUSY with counter=0, the block SHALL perform the access on the latched request at the clock edge and then enter DONE.
REQ-018 Word index SHALL be addr[ADDR_WIDTH+1:2]; addr[1:0] and the upper bits are ignored, so out-of-range addresses alias (wrap).
REQ-019 For a write, only the bytes whose wen bit is 1 SHALL be updated; data_sram_rdata is unchanged by a write.
REQ-020 For a read, data_sram_rdata SHALL be loaded with the addressed word.
REQ-021 As a result of REQ-014 to REQ-017, d_stall SHALL be high for exactly LATENCY+1 consecutive cycles per request, and data_sram_rdata SHALL be valid in the first cycle that d_stall is low.
REQ-022 Changes on the request inputs while in BUSY SHALL be ignored, including deassertion of data_sram_en; the latched request completes.
REQ-023 In DONE, the block SHALL hold data_sram_rdata stable and keep d_stall=0.
REQ-024 In DONE, the block SHALL remain in DONE while longest_stall=1, so that a request the frozen CPU holds is not re-executed.
REQ-025 In DONE with longest_stall=0, the block SHALL return to IDLE.
REQ-026 A back-to-back request SHALL be accepted in the cycle after DONE exits.
REQ-027 data_sram_rdata SHALL change only on a read completion or on reset.

Reset
REQ-028 With rst=1 at a clock edge, the block SHALL set the state to IDLE, the counter to 0 and data_sram_rdata to 0.
REQ-029 During the reset cycle, d_stall SHALL be 0.
REQ-030 Reset SHALL take priority over every other event.
REQ-031 Reset during BUSY SHALL abandon the latched request; a pending write SHALL NOT modify the memory.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-033 Reset check: assert rst for 2 cycles -> data_sram_rdata=0x00000000 and d_stall=0 during and after reset.
REQ-034 Write/read check with LATENCY=3: write wen=1111, addr=0x10, wdata=0xDEADBEEF -> d_stall=1 for exactly 4 cycles; a following read of 0x10 -> d_stall=1 for 4 cycles, then data_sram_rdata=0xDEADBEEF.
REQ-035 Byte-lane check: after REQ-034, write wen=0010, addr=0x12, wdata=0x0000AA00, then read 0x10 -> data_sram_rdata=0xDEADAAEF.
REQ-036 Freeze check: complete a read with longest_stall=1 held for 3 further cycles and inputs unchanged -> no second stall, data_sram_rdata stable; deassert longest_stall -> the next new request is accepted one cycle later.
REQ-037 Reset mid-write check: start a write of 0x12345678 to 0x20 and assert rst on the second BUSY cycle -> a later read of 0x20 returns the prior contents.
REQ-038 Alias check: write 0xCAFEF00D to byte address 0x1000 (ADDR_WIDTH=10), then read 0x0000 -> data_sram_rdata=0xCAFEF00D.
